// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - load/store arbiter in front of a single data-cache request port
//
// Purpose: selects one of the load-request port and the committed-store drain port each cycle
// and drives the cache request combinationally. It tracks loads in flight so responses can be
// forwarded or discarded after a squash, raises store priority after sustained starvation, and
// implements a fence (drain) that empties both paths before reporting completion.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   ld_valid_i/ld_ready_o/ld_addr_i  load request
//   st_valid_i/st_ready_o/st_addr_i/st_wdata_i/st_wmask_i  store drain request
//   dc_valid_o/dc_ready_i/dc_we_o/dc_addr_o/dc_wdata_o/dc_wmask_o  cache request
//   dc_rvalid_i/dc_rdata_i         in-order load response from cache
//   ld_rvalid_o/ld_rdata_o         forwarded load response
//   squash_i                       discard every load currently in flight
//   drain_req_i/drain_done_o       fence request / one-cycle completion pulse
//   stat_*_o (DCACHE_ARB_STATS_EN only)  32-bit wrapping event counters
//
// Build option: define DCACHE_ARB_STATS_EN to add the statistics counters and outputs.

module dcache_port_arbiter #(
  parameter int XLEN            = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid_i,
  output logic            ld_ready_o,
  input  logic [XLEN-1:0] ld_addr_i,
  input  logic            st_valid_i,
  output logic            st_ready_o,
  input  logic [XLEN-1:0] st_addr_i,
  input  logic [XLEN-1:0] st_wdata_i,
  input  logic [7:0]      st_wmask_i,
  output logic            dc_valid_o,
  input  logic            dc_ready_i,
  output logic            dc_we_o,
  output logic [XLEN-1:0] dc_addr_o,
  output logic [XLEN-1:0] dc_wdata_o,
  output logic [7:0]      dc_wmask_o,
  input  logic            dc_rvalid_i,
  input  logic [XLEN-1:0] dc_rdata_i,
  output logic            ld_rvalid_o,
  output logic [XLEN-1:0] ld_rdata_o,
  input  logic            squash_i,
  input  logic            drain_req_i,
  output logic            drain_done_o
`ifdef DCACHE_ARB_STATS_EN
  ,
  output logic [31:0]     stat_ld_grants_o,
  output logic [31:0]     stat_st_grants_o,
  output logic [31:0]     stat_starve_events_o,
  output logic [31:0]     stat_proto_err_o
`endif
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] OUT_MAX    = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ONE_C      = CW'(1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] ONE_S      = SW'(1);

  localparam logic [1:0] S_NORMAL    = 2'd0;
  localparam logic [1:0] S_STORE_PRI = 2'd1;
  localparam logic [1:0] S_DRAIN     = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] kill_cnt_q, kill_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          drain_done_q;

  logic ld_elig;
  logic load_sel;
  logic ld_xfer;
  logic st_xfer;
  logic resp_ok;
  logic drain_exit;

  // Request path: fully combinational mux of the selected requester.
  always_comb begin
    ld_elig  = (outstanding_q < OUT_MAX) && !squash_i && (state_q != S_DRAIN);
    load_sel = 1'b0;
    case (state_q)
      S_NORMAL:    load_sel = ld_valid_i && ld_elig;
      S_STORE_PRI: load_sel = !st_valid_i && ld_valid_i && ld_elig;
      default:     load_sel = 1'b0;
    endcase
  end

  assign dc_valid_o = load_sel ? 1'b1 : st_valid_i;
  assign dc_we_o    = !load_sel;
  assign dc_addr_o  = load_sel ? ld_addr_i : st_addr_i;
  assign dc_wdata_o = load_sel ? '0 : st_wdata_i;
  assign dc_wmask_o = load_sel ? 8'h00 : st_wmask_i;

  // load_sel already includes eligibility; the store port is ready whenever it is the selection.
  assign ld_ready_o = dc_ready_i && load_sel;
  assign st_ready_o = dc_ready_i && !load_sel;
  assign ld_xfer    = ld_ready_o;
  assign st_xfer    = st_ready_o && st_valid_i;

  // A response with nothing in flight is stale (e.g. issued before a reset) and is dropped.
  assign resp_ok     = dc_rvalid_i && (outstanding_q != '0);
  assign ld_rvalid_o = resp_ok && (kill_cnt_q == '0);
  assign ld_rdata_o  = dc_rdata_i;

  always_comb begin
    outstanding_d = outstanding_q;
    if (ld_xfer && !resp_ok)
      outstanding_d = outstanding_q + ONE_C;
    else if (!ld_xfer && resp_ok)
      outstanding_d = outstanding_q - ONE_C;
  end

  // On squash, every load still in flight after this cycle must be discarded; a response
  // arriving in the squash cycle itself is already removed from outstanding_d.
  always_comb begin
    kill_cnt_d = kill_cnt_q;
    if (squash_i)
      kill_cnt_d = outstanding_d;
    else if (resp_ok && (kill_cnt_q != '0))
      kill_cnt_d = kill_cnt_q - ONE_C;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (st_xfer)
      starve_cnt_d = '0;
    else if (st_valid_i && (starve_cnt_q != STARVE_MAX))
      starve_cnt_d = starve_cnt_q + ONE_S;
  end

  // Exit the fence once no store is pending and the last load response has arrived this cycle,
  // so the done pulse appears the cycle right after that response.
  assign drain_exit = (state_q == S_DRAIN) && !st_valid_i && (outstanding_d == '0);

  always_comb begin
    state_d = state_q;
    if (state_q == S_DRAIN) begin
      // Completion always leaves DRAIN; a held drain_req_i re-enters on the next cycle.
      if (drain_exit)
        state_d = S_NORMAL;
    end else if (drain_req_i) begin
      state_d = S_DRAIN;
    end else if (state_q == S_NORMAL) begin
      if (starve_cnt_d == STARVE_MAX)
        state_d = S_STORE_PRI;
    end else begin
      if (st_xfer || !st_valid_i)
        state_d = S_NORMAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_NORMAL;
      outstanding_q <= '0;
      kill_cnt_q    <= '0;
      starve_cnt_q  <= '0;
      drain_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      kill_cnt_q    <= kill_cnt_d;
      starve_cnt_q  <= starve_cnt_d;
      drain_done_q  <= drain_exit;
    end
  end

  assign drain_done_o = drain_done_q;

`ifdef DCACHE_ARB_STATS_EN
  logic proto_err;
  logic starve_event;

  assign proto_err    = dc_rvalid_i && (outstanding_q == '0);
  assign starve_event = (state_q == S_NORMAL) && (state_d == S_STORE_PRI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ld_grants_o     <= '0;
      stat_st_grants_o     <= '0;
      stat_starve_events_o <= '0;
      stat_proto_err_o     <= '0;
    end else begin
      if (ld_xfer)      stat_ld_grants_o     <= stat_ld_grants_o + 32'd1;
      if (st_xfer)      stat_st_grants_o     <= stat_st_grants_o + 32'd1;
      if (starve_event) stat_starve_events_o <= stat_starve_events_o + 32'd1;
      if (proto_err)    stat_proto_err_o     <= stat_proto_err_o + 32'd1;
    end
  end
`else
  // Default build carries no statistics state.
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - directed self-checking bench for dcache_port_arbiter

module tb_dcache_port_arbiter;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            ld_valid_i;
  logic            ld_ready_o;
  logic [XLEN-1:0] ld_addr_i;
  logic            st_valid_i;
  logic            st_ready_o;
  logic [XLEN-1:0] st_addr_i;
  logic [XLEN-1:0] st_wdata_i;
  logic [7:0]      st_wmask_i;
  logic            dc_valid_o;
  logic            dc_ready_i;
  logic            dc_we_o;
  logic [XLEN-1:0] dc_addr_o;
  logic [XLEN-1:0] dc_wdata_o;
  logic [7:0]      dc_wmask_o;
  logic            dc_rvalid_i;
  logic [XLEN-1:0] dc_rdata_i;
  logic            ld_rvalid_o;
  logic [XLEN-1:0] ld_rdata_o;
  logic            squash_i;
  logic            drain_req_i;
  logic            drain_done_o;

  int n_tests = 0;
  int n_fail  = 0;

  dcache_port_arbiter #(
    .XLEN(XLEN),
    .MAX_OUTSTANDING(4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ld_valid_i(ld_valid_i),
    .ld_ready_o(ld_ready_o),
    .ld_addr_i(ld_addr_i),
    .st_valid_i(st_valid_i),
    .st_ready_o(st_ready_o),
    .st_addr_i(st_addr_i),
    .st_wdata_i(st_wdata_i),
    .st_wmask_i(st_wmask_i),
    .dc_valid_o(dc_valid_o),
    .dc_ready_i(dc_ready_i),
    .dc_we_o(dc_we_o),
    .dc_addr_o(dc_addr_o),
    .dc_wdata_o(dc_wdata_o),
    .dc_wmask_o(dc_wmask_o),
    .dc_rvalid_i(dc_rvalid_i),
    .dc_rdata_i(dc_rdata_i),
    .ld_rvalid_o(ld_rvalid_o),
    .ld_rdata_o(ld_rdata_o),
    .squash_i(squash_i),
    .drain_req_i(drain_req_i),
    .drain_done_o(drain_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ldv, input logic stv, input logic rdy,
                       input logic rv, input logic sq, input logic dr);
    ld_valid_i  = ldv;
    st_valid_i  = stv;
    dc_ready_i  = rdy;
    dc_rvalid_i = rv;
    squash_i    = sq;
    drain_req_i = dr;
  endtask

  initial begin
    rst        = 1'b1;
    ld_addr_i  = 64'h1000;
    st_addr_i  = 64'h2000;
    st_wdata_i = 64'hDEAD_BEEF_0000_0001;
    st_wmask_i = 8'h0F;
    dc_rdata_i = 64'h5555;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    #1;
    check("rst_state", 64'(dut.state_q), 64'd0);
    check("rst_outstanding", 64'(dut.outstanding_q), 64'd0);
    check("rst_dc_valid", 64'(dc_valid_o), 64'd0);
    check("rst_drain_done", 64'(drain_done_o), 64'd0);
    rst = 1'b0;
    tick();

    // Starvation: 8 load transfers, store forced through in cycle 9.
    for (int c = 1; c <= 8; c++) begin
      drive(1, 1, 1, (c > 1), 0, 0);
      #1;
      check($sformatf("starve_ld_ready_c%0d", c), 64'(ld_ready_o), 64'd1);
      check($sformatf("starve_st_ready_c%0d", c), 64'(st_ready_o), 64'd0);
      check($sformatf("starve_we_c%0d", c), 64'(dc_we_o), 64'd0);
      tick();
    end
    drive(1, 1, 1, 1, 0, 0);
    #1;
    check("starve_state_pri", 64'(dut.state_q), 64'd1);
    check("starve_st_ready", 64'(st_ready_o), 64'd1);
    check("starve_ld_ready", 64'(ld_ready_o), 64'd0);
    check("starve_we", 64'(dc_we_o), 64'd1);
    check("starve_addr", dc_addr_o, 64'h2000);
    check("starve_wdata", dc_wdata_o, 64'hDEAD_BEEF_0000_0001);
    check("starve_wmask", 64'(dc_wmask_o), 64'h0F);
    check("starve_rvalid_fwd", 64'(ld_rvalid_o), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("starve_back_normal", 64'(dut.state_q), 64'd0);
    check("starve_out_zero", 64'(dut.outstanding_q), 64'd0);

    // Outstanding limit: 4 loads, 5th blocked until a response arrives.
    for (int c = 1; c <= 4; c++) begin
      drive(1, 0, 1, 0, 0, 0);
      #1;
      check($sformatf("lim_ld_ready_c%0d", c), 64'(ld_ready_o), 64'd1);
      check($sformatf("lim_addr_c%0d", c), dc_addr_o, 64'h1000);
      tick();
    end
    #1;
    check("lim_out4", 64'(dut.outstanding_q), 64'd4);
    check("lim_blocked", 64'(ld_ready_o), 64'd0);
    check("lim_dc_valid", 64'(dc_valid_o), 64'd0);
    tick();
    drive(1, 0, 1, 1, 0, 0);
    #1;
    check("lim_blocked_resp", 64'(ld_ready_o), 64'd0);
    tick();
    drive(1, 0, 1, 0, 0, 0);
    #1;
    check("lim_out3", 64'(dut.outstanding_q), 64'd3);
    check("lim_unblocked", 64'(ld_ready_o), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("lim_out4_again", 64'(dut.outstanding_q), 64'd4);
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 1, 0, 0);
      #1;
      check($sformatf("lim_resp_fwd_%0d", c), 64'(ld_rvalid_o), 64'd1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("lim_out_drained", 64'(dut.outstanding_q), 64'd0);

    // Simultaneous transfer and response at outstanding 2.
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 1, 0, 0, 0);
      tick();
    end
    drive(1, 0, 1, 1, 0, 0);
    #1;
    check("simul_ld_ready", 64'(ld_ready_o), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("simul_out2", 64'(dut.outstanding_q), 64'd2);
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 0, 1, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("simul_out0", 64'(dut.outstanding_q), 64'd0);

    // Squash with 3 loads in flight.
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 1, 0, 0, 0);
      tick();
    end
    drive(1, 0, 1, 0, 1, 0);
    #1;
    check("squash_blocks_ld", 64'(ld_ready_o), 64'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 1, 0, 0);
      #1;
      check($sformatf("squash_killed_%0d", c), 64'(ld_rvalid_o), 64'd0);
      tick();
    end
    drive(1, 0, 1, 0, 0, 0);
    #1;
    check("squash_new_ld", 64'(ld_ready_o), 64'd1);
    tick();
    dc_rdata_i = 64'hCAFE_F00D;
    drive(0, 0, 0, 1, 0, 0);
    #1;
    check("squash_new_fwd", 64'(ld_rvalid_o), 64'd1);
    check("squash_new_data", ld_rdata_o, 64'hCAFE_F00D);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("squash_out0", 64'(dut.outstanding_q), 64'd0);

    // Drain: 2 loads outstanding, 1 store pending.
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 1, 0, 0, 0);
      tick();
    end
    drive(0, 1, 0, 0, 0, 1);
    tick();
    drive(1, 1, 1, 0, 0, 0);
    #1;
    check("drain_state", 64'(dut.state_q), 64'd2);
    check("drain_no_ld", 64'(ld_ready_o), 64'd0);
    check("drain_st_ready", 64'(st_ready_o), 64'd1);
    check("drain_we", 64'(dc_we_o), 64'd1);
    tick();
    drive(1, 0, 1, 1, 0, 0);
    #1;
    check("drain_no_ld2", 64'(ld_ready_o), 64'd0);
    check("drain_resp1_fwd", 64'(ld_rvalid_o), 64'd1);
    check("drain_done_early1", 64'(drain_done_o), 64'd0);
    tick();
    drive(1, 0, 1, 1, 0, 0);
    #1;
    check("drain_no_ld3", 64'(ld_ready_o), 64'd0);
    check("drain_done_early2", 64'(drain_done_o), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    #1;
    check("drain_done_pulse", 64'(drain_done_o), 64'd1);
    check("drain_exit_normal", 64'(dut.state_q), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("drain_done_one_cycle", 64'(drain_done_o), 64'd0);
    check("drain_reenter", 64'(dut.state_q), 64'd2);
    tick();
    #1;
    check("drain_done_pulse2", 64'(drain_done_o), 64'd1);
    check("drain_exit_normal2", 64'(dut.state_q), 64'd0);

    // Reset in STORE_PRI with 3 loads outstanding.
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 1, 0, 0, 0);
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      drive(0, 1, 0, 0, 0, 0);
      tick();
    end
    #1;
    check("pre_rst_state", 64'(dut.state_q), 64'd1);
    check("pre_rst_out3", 64'(dut.outstanding_q), 64'd3);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("async_rst_state", 64'(dut.state_q), 64'd0);
    check("async_rst_out", 64'(dut.outstanding_q), 64'd0);
    check("async_rst_kill", 64'(dut.kill_cnt_q), 64'd0);
    check("async_rst_starve", 64'(dut.starve_cnt_q), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    drive(0, 0, 0, 1, 0, 0);
    #1;
    check("stray_not_fwd", 64'(ld_rvalid_o), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("stray_out0", 64'(dut.outstanding_q), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- XLEN, 64, data/address width.
- MAX_OUTSTANDING, 4, maximum loads in flight at the cache.
- STARVE_LIMIT, 8, consecutive store-losing cycles before store priority.
The block SHALL provide these three parameters.

REQ-002 Ports, one per line (name, direction, width, meaning). The block SHALL provide these ports; clock and reset are decided as follows: one clock; reset is asynchronous and active-high.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- ld_valid_i / ld_ready_o, in/out, 1/1, load request handshake.
- ld_addr_i, in, XLEN, load physical address.
- st_valid_i / st_ready_o, in/out, 1/1, committed-store drain handshake.
- st_addr_i, in, XLEN, store physical address.
- st_wdata_i, in, XLEN, store write data.
- st_wmask_i, in, 8, store byte mask.
- dc_valid_o / dc_ready_i, out/in, 1/1, cache request handshake.
- dc_we_o, out, 1, 1 = store request.
- dc_addr_o, dc_wdata_o, out, XLEN each, cache request address and write data.
- dc_wmask_o, out, 8, cache request byte mask.
- dc_rvalid_i, in, 1, in-order load response valid.
- dc_rdata_i, in, XLEN, load response data.
- ld_rvalid_o, out, 1, load response forwarded to requester.
- ld_rdata_o, out, XLEN, forwarded load response data.
- squash_i, in, 1, discard all in-flight load responses.
- drain_req_i, in, 1, fence request.
- drain_done_o, out, 1, fence completion pulse.

Function
REQ-003 The block SHALL be combinationally transparent on the request path: the granted requester's fields are muxed to dc_* in the same cycle, and dc_valid_o = granted requester's valid.

REQ-004 A grant SHALL be a transfer only when dc_valid_o && dc_ready_i; the handshake rules are:
- ld_ready_o = dc_ready_i && load selected && load eligible.
- st_ready_o = dc_ready_i && store selected.

REQ-005 Load eligibility: outstanding count < MAX_OUTSTANDING, squash_i low, and state != DRAIN.

REQ-006 The FSM SHALL have three states, NORMAL, STORE_PRI and DRAIN, with these selection rules:
- NORMAL: an eligible load wins; otherwise the store is selected.
- STORE_PRI: the store wins when st_valid_i; otherwise an eligible load.
- DRAIN: only the store is selectable.

REQ-007 starve_cnt SHALL count cycles with st_valid_i high and no store transfer; it clears on any store transfer and saturates at STARVE_LIMIT.

REQ-008 FSM transitions:
- NORMAL -> STORE_PRI when starve_cnt reaches STARVE_LIMIT.
- STORE_PRI -> NORMAL after one store transfer, or when st_valid_i is low.
- Any state -> DRAIN on drain_req_i; DRAIN has priority over all other transitions.
- DRAIN -> NORMAL when st_valid_i == 0 and outstanding == 0.

REQ-009 drain_done_o SHALL pulse high for exactly one cycle on the DRAIN -> NORMAL transition. drain_req_i held high SHALL re-enter DRAIN the following cycle.

REQ-010 The outstanding counter, width $clog2(MAX_OUTSTANDING+1), SHALL update per cycle as +1 on a load transfer and -1 on dc_rvalid_i. A simultaneous transfer and response leaves it unchanged. It never over- or under-flows; a response with outstanding == 0 is ignored and counted as protocol error only under the stats configuration.

REQ-011 kill_cnt, of the same width, SHALL discard in-flight responses:
- On squash_i, kill_cnt_d = outstanding_d, i.e. all loads still in flight after this cycle's updates.
- A dc_rvalid_i with kill_cnt_q > 0 SHALL NOT be forwarded and decrements kill_cnt.
- A response in the squash cycle is judged against kill_cnt_q.

REQ-012 ld_rvalid_o = dc_rvalid_i && kill_cnt_q == 0, and ld_rdata_o = dc_rdata_i, both with zero latency.

REQ-013 Loads SHALL be blocked (ld_ready_o = 0) in the squash_i cycle; stores are unaffected by squash.

Reset
REQ-014 rst SHALL asynchronously force:
- state = NORMAL.
- starve_cnt = 0, outstanding = 0, kill_cnt = 0.
- drain_done_o = 0.
- Statistics counters = 0.

REQ-015 Reset asserted mid-operation SHALL abandon in-flight bookkeeping. Responses arriving after reset release with outstanding == 0 are dropped per REQ-010.

Configuration
REQ-016 With DCACHE_ARB_STATS_EN defined, the block SHALL add outputs stat_ld_grants_o, stat_st_grants_o, stat_starve_events_o and stat_proto_err_o:
- Each is 32 bits and wraps modulo 2^32.
- Each increments on load transfer, store transfer, NORMAL -> STORE_PRI, and an ignored response, respectively.
Without the macro, these ports and counters SHALL be absent, with no other behavioural difference.

Verification
REQ-017 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Load and store both valid, dc_ready_i = 1 for 8 cycles -> 8 load transfers, then STORE_PRI and a store transfer in cycle 9, then NORMAL.
- 4 loads transferred with no response, 5th ld_valid_i -> ld_ready_o = 0 until a dc_rvalid_i; outstanding returns 3 -> 4.
- 3 loads in flight, squash_i for one cycle -> the next 3 dc_rvalid_i give ld_rvalid_o = 0, and the 4th (new load) is forwarded.
- drain_req_i with 2 loads outstanding and 1 store pending -> no load grants, and the store transfers; drain_done_o pulses one cycle after the 2nd response.
- Load transfer coinciding with a response at outstanding == 2 -> outstanding stays 2.
- rst asserted with outstanding == 3 in STORE_PRI -> immediately NORMAL with all counters 0; a stray response is not forwarded as an error.
